// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the CPU/display RAM arbiter.
// The ack states are one-hot so each ack output is a plain register bit.
package ram_arb_pkg;

   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_MAX_WAIT = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      CPU_ACK  = 2'b01,
      DISP_ACK = 2'b10
   } ack_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between a CPU (read/write) and a display (read-only) port.
// Grant is combinational, ack follows one cycle later; display is forced through after MAX_WAIT lost cycles.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
)(
   input  logic              clock,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic [DATA_W-1:0] cpu_q,
   output logic              cpu_ack,

   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_q,
   output logic              disp_ack,

   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   ack_state_t        state;
   ack_state_t        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              cpu_gnt;
   logic              disp_gnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   // Display only pre-empts the CPU once it has lost MAX_WAIT cycles in a row.
   always_comb begin
      cpu_gnt  = 1'b0;
      disp_gnt = 1'b0;
      if (!reset) begin
         if (disp_req && (wait_cnt == WAIT_MAX)) begin
            disp_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (disp_req) begin
            disp_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (cpu_gnt) begin
         state_nxt = CPU_ACK;
      end else if (disp_gnt) begin
         state_nxt = DISP_ACK;
      end
   end

   // Address and write data hold their last granted values when nobody wins.
   always_comb begin
      ram_wEn    = cpu_gnt & cpu_wren;
      ram_addr   = addr_q;
      ram_dataIn = data_q;
      if (reset) begin
         ram_addr   = '0;
         ram_dataIn = '0;
      end else if (cpu_gnt) begin
         ram_addr   = cpu_addr;
         ram_dataIn = cpu_data;
      end else if (disp_gnt) begin
         ram_addr   = disp_addr;
         ram_dataIn = cpu_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state <= state_nxt;
         if (!disp_req || disp_gnt) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (cpu_gnt || disp_gnt) begin
            addr_q <= ram_addr;
            data_q <= ram_dataIn;
         end
      end
   end

   assign cpu_ack  = state[0];
   assign disp_ack = state[1];

   // The RAM already registers its read port, so read data passes straight through.
   assign cpu_q  = ram_dataOut;
   assign disp_q = ram_dataOut;

endmodule
